// File: rtl/ifu_if.sv
// ifu_if: fetch-unit bus bundle between instruction memory, fetch unit and decode/next-PC stage
// master (ifu side): drives im_req/im_addr, instr_valid/instr, pc/pc4, fetch_err/err_pc;
//                    receives im_ready/im_rvalid/im_rdata, instr_ready, npc.
// slave (memory + decode side): the mirror image.
interface ifu_if;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ready;
   logic        im_rvalid;
   logic [31:0] im_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        instr_ready;
   logic [31:0] npc;
   logic        fetch_err;
   logic [31:0] err_pc;
   modport master (
      output im_req, im_addr, instr_valid, instr, pc, pc4, fetch_err, err_pc,
      input  im_ready, im_rvalid, im_rdata, instr_ready, npc
   );
   modport slave (
      input  im_req, im_addr, instr_valid, instr, pc, pc4, fetch_err, err_pc,
      output im_ready, im_rvalid, im_rdata, instr_ready, npc
   );
endinterface

// File: rtl/ifu.sv
// ifu: instruction fetch unit owning the PC; one outstanding imem read, holds word for decode, commits npc
// Ports: clk; reset (async, active-low); bus (ifu_if.master) carrying the imem request/response,
// the decode valid/ready handshake, pc/pc4, the next-PC input and the sticky fetch error.
module ifu #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter logic [31:0] IM_BYTES = 32'd16384
) (
   input logic   clk,
   input logic   reset,
   ifu_if.master bus
);
   typedef enum logic [1:0] {FETCH, WAIT, HOLD, ERR} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_d, err_pc_q, err_pc_d;
   logic        valid_q, valid_d, err_q, err_d;
   logic        accept, npc_ok;
   assign accept = valid_q && bus.instr_ready;
   // unsigned subtract: targets below PC_RESET wrap to huge values and fail the window check
   assign npc_ok = (bus.npc[1:0] == 2'b00) && ((bus.npc - PC_RESET) < IM_BYTES);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= FETCH;
         pc_q     <= PC_RESET;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         err_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         err_pc_q <= err_pc_d;
      end
   end
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      err_d    = err_q;
      err_pc_d = err_pc_q;
      case (state_q)
         FETCH: state_d = bus.im_ready ? WAIT : FETCH;
         WAIT: begin
            state_d = bus.im_rvalid ? HOLD : WAIT;
            instr_d = bus.im_rvalid ? bus.im_rdata : instr_q;
         end
         HOLD: begin
            state_d  = !accept ? HOLD : npc_ok ? FETCH : ERR;
            pc_d     = accept && npc_ok ? bus.npc : pc_q;
            err_d    = accept && !npc_ok;
            err_pc_d = accept && !npc_ok ? bus.npc : err_pc_q;
         end
         default: state_d = ERR;
      endcase
      valid_d = state_d == HOLD;
   end
   always_comb begin
      // request is gated by reset so nothing is issued while reset is held
      bus.im_req      = reset && state_q == FETCH;
      bus.im_addr     = pc_q;
      bus.instr_valid = valid_q;
      bus.instr       = instr_q;
      bus.pc          = pc_q;
      bus.pc4         = pc_q + 32'd4;
      bus.fetch_err   = err_q;
      bus.err_pc      = err_pc_q;
   end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: self-checking bench for ifu against a transaction-level model of the fetch loop
module tb_ifu;
   localparam logic [31:0] PC_RESET = 32'h0000_3000;
   localparam logic [31:0] IM_BYTES = 32'd16384;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   ifu_if bus();
   ifu #(.PC_RESET(PC_RESET), .IM_BYTES(IM_BYTES)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   // a target is fetchable if word aligned and inside [PC_RESET, PC_RESET+IM_BYTES)
   function automatic bit legal(input logic [31:0] a);
      return a[1:0] == 2'b00 && a >= PC_RESET && a <= PC_RESET + IM_BYTES - 32'd4;
   endfunction
   task automatic apply_reset;
      @(negedge clk);
      reset = 1'b0;
      bus.im_ready = 1'b0;
      bus.im_rvalid = 1'b0;
      bus.instr_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask
   // plays memory and decode for one instruction; reports what it saw, no judgement
   task automatic do_fetch(input logic [31:0] data, input int rdy_dly, input int rv_dly, input int hold_dly,
                           input logic [31:0] next, input bit stray, output logic [31:0] addr_o,
                           output logic [31:0] instr_o, output logic [31:0] pc_o, output bit stable, output bit ok);
      int n = 0;
      stable = 1'b1;
      ok = 1'b0;
      addr_o = 'x;
      instr_o = 'x;
      pc_o = 'x;
      while (bus.im_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.im_req !== 1'b1) return;
      addr_o = bus.im_addr;
      repeat (rdy_dly) begin
         bus.im_rvalid = stray;
         bus.im_rdata = $urandom;
         @(negedge clk);
         if (bus.im_req !== 1'b1 || bus.im_addr !== addr_o) stable = 1'b0;
      end
      bus.im_rvalid = 1'b0;
      bus.im_ready = 1'b1;
      @(negedge clk);
      bus.im_ready = 1'b0;
      repeat (rv_dly) begin
         if (bus.im_req !== 1'b0 || bus.instr_valid !== 1'b0) stable = 1'b0;
         @(negedge clk);
      end
      if (bus.im_req !== 1'b0) stable = 1'b0;
      bus.im_rvalid = 1'b1;
      bus.im_rdata = data;
      @(negedge clk);
      bus.im_rvalid = 1'b0;
      bus.im_rdata = $urandom;
      if (bus.instr_valid !== 1'b1) return;
      instr_o = bus.instr;
      pc_o = bus.pc;
      repeat (hold_dly) begin
         @(negedge clk);
         if (bus.instr_valid !== 1'b1 || bus.instr !== instr_o || bus.pc !== pc_o || bus.im_req !== 1'b0) stable = 1'b0;
      end
      bus.instr_ready = 1'b1;
      bus.npc = next;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      bus.npc = $urandom;
      ok = 1'b1;
   endtask
   task automatic test_reset;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.im_req !== 1'b0) begin failures++; $display("FAIL reset_im_req got=%b exp=0", bus.im_req); end
      checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.instr_valid); end
      checks++; if (bus.pc !== PC_RESET) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, PC_RESET); end
      checks++; if (bus.pc4 !== PC_RESET + 32'd4) begin failures++; $display("FAIL reset_pc4 got=%h exp=%h", bus.pc4, PC_RESET + 32'd4); end
      checks++; if (bus.instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.instr); end
      checks++; if (bus.fetch_err !== 1'b0 || bus.err_pc !== 32'h0) begin failures++; $display("FAIL reset_err got=%b/%h exp=0/0", bus.fetch_err, bus.err_pc); end
   endtask
   task automatic test_first_fetch;
      repeat (3) @(negedge clk);
      bus.im_ready = 1'b1;
      bus.instr_ready = 1'b1;
      bus.npc = 32'h3004;
      reset = 1'b1;
      #1;
      checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== 32'h3000) begin failures++; $display("FAIL first_req got=%b/%h exp=1/00003000", bus.im_req, bus.im_addr); end
      @(negedge clk);
      bus.im_rvalid = 1'b1;
      bus.im_rdata = 32'h3C01_1234;
      checks++; if (bus.im_req !== 1'b0) begin failures++; $display("FAIL first_wait_req got=%b exp=0", bus.im_req); end
      @(negedge clk);
      bus.im_rvalid = 1'b0;
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h3C01_1234) begin failures++; $display("FAIL first_instr got=%b/%h exp=1/3c011234", bus.instr_valid, bus.instr); end
      checks++; if (bus.pc !== 32'h3000 || bus.pc4 !== 32'h3004) begin failures++; $display("FAIL first_pc got=%h/%h exp=00003000/00003004", bus.pc, bus.pc4); end
      @(negedge clk);
      bus.im_ready = 1'b0;
      bus.instr_ready = 1'b0;
      checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== 32'h3004) begin failures++; $display("FAIL second_req got=%b/%h exp=1/00003004", bus.im_req, bus.im_addr); end
   endtask
   task automatic test_backpressure;
      logic [31:0] a, i, p;
      bit st, ok;
      int reqs = 0;
      logic [31:0] d = $urandom | 32'h1;
      apply_reset;
      do_fetch(d, 0, 0, 5, 32'h3008, 1'b0, a, i, p, st, ok);
      checks++; if (!ok || !st || i !== d || p !== 32'h3000) begin failures++; $display("FAIL backpressure ok=%b stable=%b instr=%h pc=%h exp instr=%h pc=00003000", ok, st, i, p, d); end
      checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== 32'h3008) begin failures++; $display("FAIL backpressure_next got=%b/%h exp=1/00003008", bus.im_req, bus.im_addr); end
      bus.im_ready = 1'b1;
      @(negedge clk);
      bus.im_ready = 1'b0;
      repeat (4) begin
         reqs += int'(bus.im_req);
         @(negedge clk);
      end
      checks++; if (reqs != 0) begin failures++; $display("FAIL backpressure_single got=%0d extra requests exp=0", reqs); end
   endtask
   task automatic test_stall;
      logic [31:0] a, i, p;
      bit st, ok;
      logic [31:0] d = $urandom | 32'h1;
      apply_reset;
      do_fetch(d, 4, 5, 0, 32'h3004, 1'b1, a, i, p, st, ok);
      checks++; if (!ok || !st || a !== 32'h3000) begin failures++; $display("FAIL stall ok=%b stable=%b addr=%h exp addr=00003000", ok, st, a); end
      checks++; if (i !== d) begin failures++; $display("FAIL stall_instr got=%h exp=%h", i, d); end
   endtask
   task automatic test_branch;
      logic [31:0] a, i, p;
      bit st, ok;
      apply_reset;
      do_fetch($urandom, 0, 0, 0, 32'h3100, 1'b0, a, i, p, st, ok);
      do_fetch($urandom, 0, 1, 0, 32'h3000, 1'b0, a, i, p, st, ok);
      checks++; if (!ok || a !== 32'h3100) begin failures++; $display("FAIL branch_3100 ok=%b got=%h exp=00003100", ok, a); end
      do_fetch($urandom, 1, 0, 1, 32'h3004, 1'b0, a, i, p, st, ok);
      checks++; if (!ok || a !== 32'h3000) begin failures++; $display("FAIL branch_3000 ok=%b got=%h exp=00003000", ok, a); end
   endtask
   task automatic test_errors;
      logic [31:0] a, i, p;
      logic [31:0] vals [3] = '{32'h7000, 32'h2FFC, 32'h6FFC};
      bit st, ok;
      int reqs = 0, vld = 0;
      apply_reset;
      do_fetch($urandom, 0, 0, 0, 32'h3100, 1'b0, a, i, p, st, ok);
      do_fetch($urandom, 0, 0, 0, 32'h3002, 1'b0, a, i, p, st, ok);
      checks++; if (!ok || bus.fetch_err !== 1'b1 || bus.err_pc !== 32'h3002) begin failures++; $display("FAIL err_misaligned ok=%b got=%b/%h exp=1/00003002", ok, bus.fetch_err, bus.err_pc); end
      checks++; if (bus.pc !== 32'h3100) begin failures++; $display("FAIL err_pc_hold got=%h exp=00003100", bus.pc); end
      bus.im_ready = 1'b1;
      bus.im_rvalid = 1'b1;
      bus.instr_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         reqs += int'(bus.im_req);
         vld += int'(bus.instr_valid);
      end
      bus.im_ready = 1'b0;
      bus.im_rvalid = 1'b0;
      bus.instr_ready = 1'b0;
      checks++; if (reqs != 0 || vld != 0 || bus.fetch_err !== 1'b1) begin failures++; $display("FAIL err_terminal got req=%0d valid=%0d err=%b exp=0/0/1", reqs, vld, bus.fetch_err); end
      foreach (vals[k]) begin
         apply_reset;
         do_fetch($urandom, 0, 0, 0, vals[k], 1'b0, a, i, p, st, ok);
         checks++; if (!ok || bus.fetch_err !== !legal(vals[k])) begin failures++; $display("FAIL err_range npc=%h got=%b exp=%b", vals[k], bus.fetch_err, !legal(vals[k])); end
      end
      checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== 32'h6FFC) begin failures++; $display("FAIL err_top_legal got=%b/%h exp=1/00006ffc", bus.im_req, bus.im_addr); end
   endtask
   task automatic test_reset_mid_wait;
      logic [31:0] a, i, p;
      bit st, ok;
      logic [31:0] d = $urandom | 32'h1;
      apply_reset;
      do_fetch(d, 0, 0, 0, 32'h3200, 1'b0, a, i, p, st, ok);
      bus.im_ready = 1'b1;
      @(negedge clk);
      bus.im_ready = 1'b0;
      #2 reset = 1'b0;
      #1;
      checks++; if (bus.im_req !== 1'b0 || bus.pc !== 32'h3000 || bus.instr !== 32'h0 || bus.instr_valid !== 1'b0 || bus.pc4 !== 32'h3004)
         begin failures++; $display("FAIL midwait_reset got req=%b pc=%h instr=%h valid=%b pc4=%h exp 0/00003000/0/0/00003004", bus.im_req, bus.pc, bus.instr, bus.instr_valid, bus.pc4); end
      @(negedge clk);
      reset = 1'b1;
      bus.im_rvalid = 1'b1;
      bus.im_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.im_rvalid = 1'b0;
      checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== 32'h3000 || bus.instr !== 32'h0) begin failures++; $display("FAIL midwait_restart got req=%b addr=%h instr=%h exp 1/00003000/0", bus.im_req, bus.im_addr, bus.instr); end
      do_fetch(d, 0, 0, 0, 32'h3004, 1'b0, a, i, p, st, ok);
      checks++; if (!ok || a !== 32'h3000 || i !== d) begin failures++; $display("FAIL midwait_refetch ok=%b addr=%h instr=%h exp 00003000/%h", ok, a, i, d); end
   endtask
   task automatic test_random;
      logic [31:0] a, i, p, d, nxt;
      logic [31:0] exp_pc = PC_RESET;
      bit st, ok;
      apply_reset;
      for (int n = 0; n < 40; n++) begin
         d = $urandom;
         nxt = PC_RESET + 32'd4 * 32'($urandom_range(0, 4095));
         do_fetch(d, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3), nxt, 1'($urandom_range(0, 1)), a, i, p, st, ok);
         checks++; if (!ok || !st || a !== exp_pc || i !== d || p !== exp_pc)
            begin failures++; $display("FAIL random[%0d] ok=%b stable=%b addr=%h instr=%h pc=%h exp addr/pc=%h instr=%h", n, ok, st, a, i, p, exp_pc, d); end
         exp_pc = nxt;
      end
   endtask
   task automatic test_random_legality;
      logic [31:0] a, i, p, v;
      bit st, ok;
      for (int n = 0; n < 12; n++) begin
         case (n % 3)
            0: v = $urandom;
            1: v = PC_RESET + 32'($urandom_range(0, 16)) - 32'd8;
            default: v = PC_RESET + IM_BYTES + 32'($urandom_range(0, 16)) - 32'd8;
         endcase
         apply_reset;
         do_fetch($urandom, 0, 0, 0, v, 1'b0, a, i, p, st, ok);
         checks++; if (!ok || bus.fetch_err !== !legal(v) || (legal(v) ? bus.im_addr !== v : bus.err_pc !== v))
            begin failures++; $display("FAIL legality npc=%h got err=%b addr=%h err_pc=%h exp err=%b", v, bus.fetch_err, bus.im_addr, bus.err_pc, !legal(v)); end
      end
   endtask
   initial begin
      reset = 1'b0;
      bus.im_ready = 1'b0;
      bus.im_rvalid = 1'b0;
      bus.im_rdata = '0;
      bus.instr_ready = 1'b0;
      bus.npc = '0;
      test_reset;
      test_first_fetch;
      test_backpressure;
      test_stall;
      test_branch;
      test_errors;
      test_reset_mid_wait;
      test_random;
      test_random_legality;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: owns the architectural PC register and consumes the next-PC value produced by the next-PC logic. It issues one instruction-memory read per instruction over a request/response handshake, holds the fetched word for decode over a valid/ready handshake, and reloads the PC from the next-PC input when decode accepts the word. It sits between the instruction memory and the decode/next-PC stage. It closes the loop: the next-PC logic computes the target, this block commits it.

## Interface
- PC_RESET, 32'h0000_3000, PC value after reset; base of the instruction memory window.
- IM_BYTES, 16384, size of the legal fetch window in bytes (multiple of 4).

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- im_req  out  1  read request valid.
- im_addr  out  32  word-aligned byte address of the request; equals current PC.
- im_ready  in  1  memory accepts the request when im_req && im_ready.
- im_rvalid  in  1  read data valid.
- im_rdata  in  32  instruction word.
- instr_valid  out  1  fetched instruction available to decode.
- instr  out  32  fetched instruction.
- pc  out  32  address of instr / current PC.
- pc4  out  32  pc + 4, mod 2^32, combinational; used as the link value.
- instr_ready  in  1  decode consumes the instruction when instr_valid && instr_ready.
- npc  in  32  next PC from the next-PC logic, valid in the accept cycle.
- fetch_err  out  1  sticky address-error flag.
- err_pc  out  32  offending npc value, captured on error.

## Operation
- States: FETCH, WAIT, HOLD, ERR. Exactly one memory request is outstanding at a time.
- FETCH: im_req=1, im_addr=pc. On im_ready, go to WAIT. Otherwise stay, with im_req and im_addr held stable.
- WAIT: im_req=0. On im_rvalid, latch instr<=im_rdata and go to HOLD. im_rvalid in any other state is ignored; no data is latched.
- HOLD: instr_valid=1. instr and pc stay stable until accepted. On instr_valid && instr_ready, check npc:
  - Legal: npc[1:0]==0 and (npc - PC_RESET) < IM_BYTES. The subtraction is a 32-bit unsigned subtract, so npc < PC_RESET wraps and fails the check. Then pc<=npc and the state goes to FETCH.
  - Illegal: err_pc<=npc, fetch_err<=1, state goes to ERR, and pc is unchanged.
- ERR: terminal. im_req=0, instr_valid=0, fetch_err=1. Only reset exits.
- instr_valid is registered. It is 1 exactly in HOLD.
- npc is sampled only in the accept cycle; its value in other cycles is don't-care.

## Timing
- Reset asserted (async, immediate) forces:
  - state=FETCH, pc=PC_RESET, instr=0, instr_valid=0, fetch_err=0, err_pc=0.
  - im_req is gated to 0 while reset is low.
  - pc4=PC_RESET+4.
- First request: im_req=1, im_addr=PC_RESET in the first clock cycle after reset deasserts.
- Minimum cycles per instruction is 3, with im_ready=1 and im_rvalid one cycle after the handshake:
  - cycle n: FETCH handshake;
  - cycle n+1: WAIT with rvalid;
  - cycle n+2: HOLD with accept;
  - cycle n+3: FETCH of npc.
- Memory latency is unbounded. The block waits in WAIT indefinitely. im_rvalid in the handshake cycle itself is not used.
- Decode back-pressure is unbounded. The block waits in HOLD indefinitely, with no PC change.
- Reset mid-transaction (FETCH, WAIT or HOLD):
  - all state is abandoned;
  - a late im_rvalid from the abandoned request that arrives while the block is in FETCH is ignored;
  - the memory system must drop in-flight responses on reset.
- pc4 at pc=32'hFFFF_FFFC wraps to 0. That value is unreachable with default parameters, but the wrap is required.

## Test plan
- Reset/first fetch: hold reset low 3 cycles, then release with im_ready=1 and rdata=32'h3C01_1234 one cycle later, instr_ready=1, npc=32'h3004. Required: im_addr=32'h3000 in cycle 1; instr_valid=1 with instr=32'h3C01_1234, pc=32'h3000, pc4=32'h3004 in cycle 3; im_addr=32'h3004 in cycle 4.
- Back-pressure: instr_ready=0 for 5 cycles in HOLD. Required: instr and pc stable; im_req=0 throughout; exactly one fetch after instr_ready rises.
- Memory stall: im_ready=0 for 4 cycles, then im_rvalid 6 cycles after the handshake. Required: im_addr stable while waiting; a stray im_rvalid during FETCH does not change instr.
- Branch/jump target: accept with npc=32'h0000_3100, then with npc=32'h0000_3000. Required: the next im_addr values are 32'h3100, then 32'h3000.
- Address errors:
  - npc=32'h3002: fetch_err=1, err_pc=32'h3002, pc stays at its prior value, no further im_req.
  - Separately, npc=32'h7000 and npc=32'h2FFC: each gives fetch_err=1.
  - npc=32'h6FFC: legal.
- Reset mid-WAIT: assert reset while a request is outstanding. Required: outputs go to reset values immediately; after release, the fetch restarts at 32'h3000.
